// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS decode/execute slice: ALU op codes,
// opcode/funct values, destination/write-back/operand select encodings
// and the decoded control bundle.
package mips_pkg;

   // ALU operation codes (5-bit ctrl_alu field)
   localparam logic [4:0] ALU_ADD  = 5'd0;
   localparam logic [4:0] ALU_SUB  = 5'd1;
   localparam logic [4:0] ALU_AND  = 5'd2;
   localparam logic [4:0] ALU_OR   = 5'd3;
   localparam logic [4:0] ALU_XOR  = 5'd4;
   localparam logic [4:0] ALU_NOR  = 5'd5;
   localparam logic [4:0] ALU_SLT  = 5'd6;
   localparam logic [4:0] ALU_SLTU = 5'd7;
   localparam logic [4:0] ALU_SLL  = 5'd8;
   localparam logic [4:0] ALU_SRL  = 5'd9;
   localparam logic [4:0] ALU_SRA  = 5'd10;
   localparam logic [4:0] ALU_LUI  = 5'd11;
   localparam logic [4:0] ALU_ADDU = 5'd12;
   localparam logic [4:0] ALU_SUBU = 5'd13;

   // Primary opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes (instr[5:0])
   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_SLLV = 6'h04;
   localparam logic [5:0] F_SRLV = 6'h06;
   localparam logic [5:0] F_SRAV = 6'h07;
   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_SLTU = 6'h2B;

   // Destination register select
   localparam logic [1:0] RDST_RT  = 2'd0;
   localparam logic [1:0] RDST_RD  = 2'd1;
   localparam logic [1:0] RDST_R31 = 2'd2;

   // Write-back source select
   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   // ALU operand selects
   typedef enum logic [0:0] {SRCA_RS = 1'b0, SRCA_RT = 1'b1} src_a_e;
   typedef enum logic [1:0] {
      SRCB_RT    = 2'd0,   // rt_data
      SRCB_SHAMT = 2'd1,   // instr[10:6] zero-extended
      SRCB_RS_LO = 2'd2,   // rs_data[4:0] zero-extended
      SRCB_IMM   = 2'd3    // extended immediate
   } src_b_e;

   // Decoded control bundle
   typedef struct packed {
      logic [4:0] alu_op;
      logic [1:0] reg_dst;
      logic [1:0] mem2reg;
      logic       reg_wr;
      logic       mem_wr;
      logic       sign_ext;
      src_a_e     src_a;
      src_b_e     src_b;
   } ctrl_t;

   // Safe decode for undefined instructions: no writes, ADD, all selects 0
   localparam ctrl_t CTRL_NOP = '{
      alu_op:   ALU_ADD,
      reg_dst:  RDST_RT,
      mem2reg:  WB_ALU,
      reg_wr:   1'b0,
      mem_wr:   1'b0,
      sign_ext: 1'b0,
      src_a:    SRCA_RS,
      src_b:    SRCB_RT
   };

endpackage

// File: rtl/mips_alu_core.sv
// Combinational 32-bit MIPS ALU: op + A + B -> result and signed
// overflow. Overflow is reported for ALU_ADD and ALU_SUB only; the
// wrapping ADDU/SUBU variants never raise it.
module mips_alu_core
   import mips_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [4:0]        i_op,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic [DATA_W-1:0] o_result,
   output logic              o_overflow
);

   localparam int MSB = DATA_W - 1;

   logic [DATA_W-1:0] w_sum;
   logic [DATA_W-1:0] w_diff;
   logic [4:0]        w_shamt;
   logic              w_add_ovf;
   logic              w_sub_ovf;

   assign w_sum   = i_a + i_b;
   assign w_diff  = i_a - i_b;
   assign w_shamt = i_b[4:0];

   // Overflow when operand signs allow it and the result sign flips
   assign w_add_ovf = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB]  != i_a[MSB]);
   assign w_sub_ovf = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);

   // Result mux over all ALU operations; unused op codes give zero
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      o_result   = '0;
      o_overflow = 1'b0;
      case (i_op)
         ALU_ADD:  begin o_result = w_sum;  o_overflow = w_add_ovf; end
         ALU_SUB:  begin o_result = w_diff; o_overflow = w_sub_ovf; end
         ALU_ADDU: o_result = w_sum;
         ALU_SUBU: o_result = w_diff;
         ALU_AND:  o_result = i_a & i_b;
         ALU_OR:   o_result = i_a | i_b;
         ALU_XOR:  o_result = i_a ^ i_b;
         ALU_NOR:  o_result = ~(i_a | i_b);
         ALU_SLT:  o_result = {{(DATA_W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         ALU_SLTU: o_result = {{(DATA_W-1){1'b0}}, (i_a < i_b)};
         ALU_SLL:  o_result = i_a << w_shamt;
         ALU_SRL:  o_result = i_a >> w_shamt;
         ALU_SRA:  o_result = DATA_W'($signed(i_a) >>> w_shamt);
         ALU_LUI:  o_result = {i_b[15:0], {(DATA_W-16){1'b0}}};
         default:  o_result = '0;
      endcase
   end

endmodule

// File: rtl/mips_ctrl_alu_stage.sv
// Single-cycle MIPS decode/execute slice: main control decoder,
// 16->32 immediate extender and ALU, with every output registered
// (latency exactly one cycle, no handshake).
// Optional build macro OVF_TRAP_EN: report signed ADD/SUB overflow and
// suppress the register write of the overflowing instruction. Without
// it, overflow is tied low and reg_wr is never suppressed.
// Writes to register 0 are still flagged; the register file drops them.
module mips_ctrl_alu_stage
   import mips_pkg::*;
#(
   parameter int DATA_W = 32   // only 32 is supported
) (
   input  logic              clk,
   input  logic              rst,          // asynchronous, active low
   input  logic [31:0]       instr,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   output logic [DATA_W-1:0] alu_result,
   output logic              zero,
   output logic              overflow,
   output logic [DATA_W-1:0] ext_imm,
   output logic [DATA_W-1:0] store_data,
   output logic [4:0]        ctrl_alu,
   output logic [1:0]        reg_dst,
   output logic [1:0]        mem2reg,
   output logic              reg_wr,
   output logic              mem_wr
);

   logic [5:0]        w_op;
   logic [5:0]        w_funct;
   logic [15:0]       w_imm;
   ctrl_t             w_ctrl;
   logic [DATA_W-1:0] w_ext_imm;
   logic [DATA_W-1:0] w_op_a;
   logic [DATA_W-1:0] w_op_b;
   logic [DATA_W-1:0] w_alu_result;
   logic              w_alu_ovf;
   logic              w_overflow;
   logic              w_reg_wr;
   logic              w_unused_fields;

   logic [DATA_W-1:0] r_alu_result;
   logic              r_zero;
   logic              r_overflow;
   logic [DATA_W-1:0] r_ext_imm;
   logic [DATA_W-1:0] r_store_data;
   logic [4:0]        r_ctrl_alu;
   logic [1:0]        r_reg_dst;
   logic [1:0]        r_mem2reg;
   logic              r_reg_wr;
   logic              r_mem_wr;

   assign w_op    = instr[31:26];
   assign w_funct = instr[5:0];
   assign w_imm   = instr[15:0];

   // Register indices and jump targets are consumed by other stages
   assign w_unused_fields = ^instr[25:16];

   // Main control decode: opcode first, funct for R-type
   always_comb begin
      w_ctrl = CTRL_NOP;
      case (w_op)
         OP_RTYPE: begin
            w_ctrl.reg_dst = RDST_RD;
            w_ctrl.reg_wr  = 1'b1;
            case (w_funct)
               F_ADD:  w_ctrl.alu_op = ALU_ADD;
               F_ADDU: w_ctrl.alu_op = ALU_ADDU;
               F_SUB:  w_ctrl.alu_op = ALU_SUB;
               F_SUBU: w_ctrl.alu_op = ALU_SUBU;
               F_AND:  w_ctrl.alu_op = ALU_AND;
               F_OR:   w_ctrl.alu_op = ALU_OR;
               F_XOR:  w_ctrl.alu_op = ALU_XOR;
               F_NOR:  w_ctrl.alu_op = ALU_NOR;
               F_SLT:  w_ctrl.alu_op = ALU_SLT;
               F_SLTU: w_ctrl.alu_op = ALU_SLTU;
               F_SLL:  begin w_ctrl.alu_op = ALU_SLL; w_ctrl.src_a = SRCA_RT; w_ctrl.src_b = SRCB_SHAMT; end
               F_SRL:  begin w_ctrl.alu_op = ALU_SRL; w_ctrl.src_a = SRCA_RT; w_ctrl.src_b = SRCB_SHAMT; end
               F_SRA:  begin w_ctrl.alu_op = ALU_SRA; w_ctrl.src_a = SRCA_RT; w_ctrl.src_b = SRCB_SHAMT; end
               F_SLLV: begin w_ctrl.alu_op = ALU_SLL; w_ctrl.src_a = SRCA_RT; w_ctrl.src_b = SRCB_RS_LO; end
               F_SRLV: begin w_ctrl.alu_op = ALU_SRL; w_ctrl.src_a = SRCA_RT; w_ctrl.src_b = SRCB_RS_LO; end
               F_SRAV: begin w_ctrl.alu_op = ALU_SRA; w_ctrl.src_a = SRCA_RT; w_ctrl.src_b = SRCB_RS_LO; end
               F_JR:   begin w_ctrl.reg_dst = RDST_RT; w_ctrl.reg_wr = 1'b0; end
               default: w_ctrl = CTRL_NOP;
            endcase
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
            w_ctrl.reg_wr   = 1'b1;
            w_ctrl.sign_ext = 1'b1;
            w_ctrl.src_b    = SRCB_IMM;
            case (w_op)
               OP_ADDI:  w_ctrl.alu_op = ALU_ADD;
               OP_ADDIU: w_ctrl.alu_op = ALU_ADDU;
               OP_SLTI:  w_ctrl.alu_op = ALU_SLT;
               default:  w_ctrl.alu_op = ALU_SLTU;
            endcase
         end
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            w_ctrl.reg_wr = 1'b1;
            w_ctrl.src_b  = SRCB_IMM;
            case (w_op)
               OP_ANDI: w_ctrl.alu_op = ALU_AND;
               OP_ORI:  w_ctrl.alu_op = ALU_OR;
               OP_XORI: w_ctrl.alu_op = ALU_XOR;
               default: w_ctrl.alu_op = ALU_LUI;
            endcase
         end
         OP_LW: begin
            w_ctrl.mem2reg  = WB_MEM;
            w_ctrl.reg_wr   = 1'b1;
            w_ctrl.sign_ext = 1'b1;
            w_ctrl.src_b    = SRCB_IMM;
         end
         OP_SW: begin
            w_ctrl.mem_wr   = 1'b1;
            w_ctrl.sign_ext = 1'b1;
            w_ctrl.src_b    = SRCB_IMM;
         end
         OP_BEQ, OP_BNE: begin
            w_ctrl.alu_op   = ALU_SUB;
            w_ctrl.sign_ext = 1'b1;
         end
         OP_J: w_ctrl = CTRL_NOP;
         OP_JAL: begin
            w_ctrl.reg_dst = RDST_R31;
            w_ctrl.mem2reg = WB_PC4;
            w_ctrl.reg_wr  = 1'b1;
         end
         default: w_ctrl = CTRL_NOP;
      endcase
   end

   // Immediate extension: sign for arithmetic/memory/branch, zero otherwise
   assign w_ext_imm = w_ctrl.sign_ext ? {{(DATA_W-16){w_imm[15]}}, w_imm}
                                      : {{(DATA_W-16){1'b0}}, w_imm};

   // Operand selection for the ALU
   always_comb begin
      w_op_a = (w_ctrl.src_a == SRCA_RT) ? rt_data : rs_data;
      case (w_ctrl.src_b)
         SRCB_SHAMT: w_op_b = {{(DATA_W-5){1'b0}}, instr[10:6]};
         SRCB_RS_LO: w_op_b = {{(DATA_W-5){1'b0}}, rs_data[4:0]};
         SRCB_IMM:   w_op_b = w_ext_imm;
         default:    w_op_b = rt_data;
      endcase
   end

   mips_alu_core #(
      .DATA_W (DATA_W)
   ) u_alu (
      .i_op       (w_ctrl.alu_op),
      .i_a        (w_op_a),
      .i_b        (w_op_b),
      .o_result   (w_alu_result),
      .o_overflow (w_alu_ovf)
   );

`ifdef OVF_TRAP_EN
   assign w_overflow = w_alu_ovf;
   assign w_reg_wr   = w_ctrl.reg_wr & ~w_alu_ovf;
`else
   logic w_unused_ovf;
   assign w_unused_ovf = w_alu_ovf;
   assign w_overflow   = 1'b0;
   assign w_reg_wr     = w_ctrl.reg_wr;
`endif

   // Output register stage, cleared asynchronously by rst low
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_alu_result <= '0;
         r_zero       <= 1'b0;
         r_overflow   <= 1'b0;
         r_ext_imm    <= '0;
         r_store_data <= '0;
         r_ctrl_alu   <= '0;
         r_reg_dst    <= '0;
         r_mem2reg    <= '0;
         r_reg_wr     <= 1'b0;
         r_mem_wr     <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         r_alu_result <= w_alu_result;
         r_zero       <= (w_alu_result == '0);
         r_overflow   <= w_overflow;
         r_ext_imm    <= w_ext_imm;
         r_store_data <= rt_data;
         r_ctrl_alu   <= w_ctrl.alu_op;
         r_reg_dst    <= w_ctrl.reg_dst;
         r_mem2reg    <= w_ctrl.mem2reg;
         r_reg_wr     <= w_reg_wr;
         r_mem_wr     <= w_ctrl.mem_wr;
      end
   end

   assign alu_result = r_alu_result;
   assign zero       = r_zero;
   assign overflow   = r_overflow;
   assign ext_imm    = r_ext_imm;
   assign store_data = r_store_data;
   assign ctrl_alu   = r_ctrl_alu;
   assign reg_dst    = r_reg_dst;
   assign mem2reg    = r_mem2reg;
   assign reg_wr     = r_reg_wr;
   assign mem_wr     = r_mem_wr;

endmodule

// File: tb/tb_mips_ctrl_alu_stage.sv
// Directed bench for mips_ctrl_alu_stage with hand-computed expectations.
// Overflow expectations follow the OVF_TRAP_EN macro of the build.
module tb_mips_ctrl_alu_stage;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [31:0] alu_result;
   logic        zero;
   logic        overflow;
   logic [31:0] ext_imm;
   logic [31:0] store_data;
   logic [4:0]  ctrl_alu;
   logic [1:0]  reg_dst;
   logic [1:0]  mem2reg;
   logic        reg_wr;
   logic        mem_wr;

   int n_checks = 0;
   int n_pass   = 0;

   mips_ctrl_alu_stage #(.DATA_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .instr      (instr),
      .rs_data    (rs_data),
      .rt_data    (rt_data),
      .alu_result (alu_result),
      .zero       (zero),
      .overflow   (overflow),
      .ext_imm    (ext_imm),
      .store_data (store_data),
      .ctrl_alu   (ctrl_alu),
      .reg_dst    (reg_dst),
      .mem2reg    (mem2reg),
      .reg_wr     (reg_wr),
      .mem_wr     (mem_wr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
   endtask

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   // Apply one instruction and sample just after the capturing edge
   task automatic step(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
      instr   = ins;
      rs_data = rs;
      rt_data = rt;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".alu"},   alu_result, 32'h0);
      check({tag, ".zero"},  {31'h0, zero}, 32'h0);
      check({tag, ".ovf"},   {31'h0, overflow}, 32'h0);
      check({tag, ".ext"},   ext_imm, 32'h0);
      check({tag, ".store"}, store_data, 32'h0);
      check({tag, ".ctrl"},  {27'h0, ctrl_alu}, 32'h0);
      check({tag, ".rdst"},  {30'h0, reg_dst}, 32'h0);
      check({tag, ".m2r"},   {30'h0, mem2reg}, 32'h0);
      check({tag, ".rwr"},   {31'h0, reg_wr}, 32'h0);
      check({tag, ".mwr"},   {31'h0, mem_wr}, 32'h0);
   endtask

   logic exp_ovf;
   logic exp_wr;

   initial begin
      rst     = 1'b0;
      instr   = 32'h0;
      rs_data = 32'h0;
      rt_data = 32'h0;
      #2;
      check_all_zero("reset");
      rst = 1'b1;

      // addi $t0,$t1,-1 with rs=5
      step(itype(6'h08, 5'd9, 5'd8, 16'hFFFF), 32'd5, 32'h0);
      check("addi.ext",  ext_imm, 32'hFFFF_FFFF);
      check("addi.alu",  alu_result, 32'd4);
      check("addi.rdst", {30'h0, reg_dst}, 32'd0);
      check("addi.rwr",  {31'h0, reg_wr}, 32'd1);
      check("addi.ctrl", {27'h0, ctrl_alu}, 32'd0);

      // sll rd,rt,4
      step(rtype(5'd0, 5'd9, 5'd8, 5'd4, 6'h00), 32'h0, 32'h0000_000F);
      check("sll.alu",  alu_result, 32'h0000_00F0);
      check("sll.rdst", {30'h0, reg_dst}, 32'd1);
      check("sll.ctrl", {27'h0, ctrl_alu}, 32'd8);

      // sra by 4 on 0x80000000
      step(rtype(5'd0, 5'd9, 5'd8, 5'd4, 6'h03), 32'h0, 32'h8000_0000);
      check("sra.alu", alu_result, 32'hF800_0000);

      // srl by 31 on 0x80000000 (maximum shift amount)
      step(rtype(5'd0, 5'd9, 5'd8, 5'd31, 6'h02), 32'h0, 32'h8000_0000);
      check("srl31.alu", alu_result, 32'h0000_0001);

      // srav: amount from rs[4:0] = 4, upper rs bits ignored
      step(rtype(5'd1, 5'd9, 5'd8, 5'd0, 6'h07), 32'h0000_0024, 32'h8000_0000);
      check("srav.alu", alu_result, 32'hF800_0000);

      // lui 0x1234
      step(itype(6'h0F, 5'd0, 5'd8, 16'h1234), 32'hFFFF_FFFF, 32'h0);
      check("lui.alu",  alu_result, 32'h1234_0000);
      check("lui.ctrl", {27'h0, ctrl_alu}, 32'd11);

      // ori 0x8000 with rs=0: zero-extended
      step(itype(6'h0D, 5'd0, 5'd8, 16'h8000), 32'h0, 32'h0);
      check("ori.alu", alu_result, 32'h0000_8000);
      check("ori.ext", ext_imm, 32'h0000_8000);

      // sltiu with imm 0xFFFF: sign-extended, 5 <u 0xFFFFFFFF
      step(itype(6'h0B, 5'd1, 5'd8, 16'hFFFF), 32'd5, 32'h0);
      check("sltiu.alu", alu_result, 32'd1);

      // slt vs sltu with -1 and 1
      step(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h2A), 32'hFFFF_FFFF, 32'd1);
      check("slt.alu", alu_result, 32'd1);
      step(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h2B), 32'hFFFF_FFFF, 32'd1);
      check("sltu.alu", alu_result, 32'd0);
      check("sltu.zero", {31'h0, zero}, 32'd1);

      // nor
      step(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h27), 32'hF0F0_F0F0, 32'h0F0F_0000);
      check("nor.alu", alu_result, 32'h0000_0F0F);

      // subu wraps
      step(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h23), 32'd1, 32'd2);
      check("subu.alu", alu_result, 32'hFFFF_FFFF);
      check("subu.ovf", {31'h0, overflow}, 32'd0);

      // beq with rs = rt = 7
      step(itype(6'h04, 5'd1, 5'd2, 16'h0010), 32'd7, 32'd7);
      check("beq.zero", {31'h0, zero}, 32'd1);
      check("beq.rwr",  {31'h0, reg_wr}, 32'd0);
      check("beq.mwr",  {31'h0, mem_wr}, 32'd0);
      check("beq.ctrl", {27'h0, ctrl_alu}, 32'd1);

      // lw: address rs + sign-extended -4
      step(itype(6'h23, 5'd1, 5'd2, 16'hFFFC), 32'h0000_0100, 32'h0);
      check("lw.alu", alu_result, 32'h0000_00FC);
      check("lw.m2r", {30'h0, mem2reg}, 32'd1);
      check("lw.rwr", {31'h0, reg_wr}, 32'd1);

      // jal
      step({6'h03, 26'h0000040}, 32'h0, 32'h0);
      check("jal.rdst", {30'h0, reg_dst}, 32'd2);
      check("jal.m2r",  {30'h0, mem2reg}, 32'd2);
      check("jal.rwr",  {31'h0, reg_wr}, 32'd1);

      // jr: no write
      step(rtype(5'd31, 5'd0, 5'd0, 5'd0, 6'h08), 32'h0000_1000, 32'h0);
      check("jr.rwr", {31'h0, reg_wr}, 32'd0);

      // undefined opcode: ADD of rs and rt, no writes, selects 0
      step(itype(6'h3F, 5'd1, 5'd2, 16'hABCD), 32'd3, 32'd4);
      check("undef.alu",  alu_result, 32'd7);
      check("undef.rwr",  {31'h0, reg_wr}, 32'd0);
      check("undef.mwr",  {31'h0, mem_wr}, 32'd0);
      check("undef.rdst", {30'h0, reg_dst}, 32'd0);
      check("undef.m2r",  {30'h0, mem2reg}, 32'd0);

      // signed overflow on add; addu with the same operands never traps
`ifdef OVF_TRAP_EN
      exp_ovf = 1'b1;
      exp_wr  = 1'b0;
`else
      exp_ovf = 1'b0;
      exp_wr  = 1'b1;
`endif
      step(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'h7FFF_FFFF, 32'd1);
      check("add.alu", alu_result, 32'h8000_0000);
      check("add.ovf", {31'h0, overflow}, {31'h0, exp_ovf});
      check("add.rwr", {31'h0, reg_wr}, {31'h0, exp_wr});
      step(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'h7FFF_FFFF, 32'd1);
      check("addu.alu", alu_result, 32'h8000_0000);
      check("addu.ovf", {31'h0, overflow}, 32'd0);
      check("addu.rwr", {31'h0, reg_wr}, 32'd1);

      // sw, then asynchronous reset mid-cycle with no clock edge
      step(itype(6'h2B, 5'd1, 5'd2, 16'h0004), 32'h0000_0100, 32'hDEAD_BEEF);
      check("sw.mwr",   {31'h0, mem_wr}, 32'd1);
      check("sw.store", store_data, 32'hDEAD_BEEF);
      check("sw.alu",   alu_result, 32'h0000_0104);
      check("sw.rwr",   {31'h0, reg_wr}, 32'd0);
      rst = 1'b0;
      #1;
      check_all_zero("midrst");
      rst = 1'b1;

      // first instruction after reset release
      step(itype(6'h0E, 5'd0, 5'd8, 16'hFFFF), 32'h0, 32'h0);
      check("xori.alu", alu_result, 32'h0000_FFFF);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mips_ctrl_alu_stage.md
Name: mips_ctrl_alu_stage

Overview:
- Single-cycle-MIPS decode/execute slice merging the main control decoder, the 16→32 immediate extender and the 32-bit ALU.
- Takes the fetched instruction plus the rs/rt register-file read data.
- Drives registered control signals, extended immediate, ALU result, zero flag and store data to the memory/write-back logic one cycle later.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- instr  in  32  current instruction
- rs_data  in  32  register-file read port 1 (instr[25:21])
- rt_data  in  32  register-file read port 2 (instr[20:16])
- alu_result  out  32  registered ALU output
- zero  out  1  registered (alu_result == 0)
- overflow  out  1  registered signed overflow (see Optional Feature)
- ext_imm  out  32  registered extended immediate
- store_data  out  32  registered rt_data
- ctrl_alu  out  5  registered ALU op code
- reg_dst  out  2  registered destination select: 0 = rt, 1 = rd, 2 = r31
- mem2reg  out  2  registered write-back select: 0 = ALU, 1 = memory, 2 = PC+4
- reg_wr  out  1  registered register-file write enable
- mem_wr  out  1  registered data-memory write enable

Behaviour:
- Reset (rst = 0, asynchronous) clears every output to 0.
- Decode, extend and ALU logic are combinational. All outputs are captured on each rising clk edge, so latency is exactly 1 cycle and no handshake exists.
- Extension:
  - Sign-extend for addi, addiu, slti, sltiu, lw, sw, beq, bne.
  - Zero-extend for andi, ori, xori, lui.
- Operand A select:
  - rt_data for sll, srl, sra, sllv, srlv, srav.
  - rs_data otherwise.
- Operand B select:
  - Zero-extended instr[10:6] for sll/srl/sra.
  - {27'b0, rs_data[4:0]} for variable shifts.
  - ext_imm for I-type ALU ops and lw/sw.
  - rt_data otherwise.
- ALU op codes:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLTU=7, SLL=8, SRL=9, SRA=10, LUI=11, ADDU=12, SUBU=13.
  - Shifts use B[4:0] as the amount.
  - LUI gives {B[15:0], 16'h0}.
  - SLT is a signed compare; SLTU is an unsigned compare.
  - Results wrap modulo 2^32.
- R-type decode (op = 0) by funct:
  - 0x20 add, 0x21 addu, 0x22 sub, 0x23 subu, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt, 0x2B sltu, 0x00 sll, 0x02 srl, 0x03 sra, 0x04 sllv, 0x06 srlv, 0x07 srav.
  - All of these: reg_dst = 1, reg_wr = 1.
  - jr (0x08): reg_wr = 0, ADD.
- I-type decode by op:
  - ALU immediates (reg_dst = 0, reg_wr = 1): addi 0x08 ADD, addiu 0x09 ADDU, slti 0x0A SLT, sltiu 0x0B SLTU, andi 0x0C AND, ori 0x0D OR, xori 0x0E XOR, lui 0x0F LUI.
  - lw 0x23: ADD, mem2reg = 1, reg_wr = 1.
  - sw 0x2B: ADD, mem_wr = 1.
  - beq 0x04, bne 0x05: SUB, no writes.
  - j 0x02: no writes.
  - jal 0x03: reg_dst = 2, mem2reg = 2, reg_wr = 1.
- Undefined op/funct: reg_wr = mem_wr = 0, op ADD, all selects 0.
- Register 0 writes are still flagged; suppressing them is the register file's job.

Optional Feature:
- Macro OVF_TRAP_EN.
- When defined:
  - overflow = signed overflow of ADD/SUB only (addu/subu/addiu never set it).
  - reg_wr is forced to 0 for that instruction when overflow occurs.
- When undefined: overflow is tied 0 and reg_wr is never suppressed.

Decomposition:
- Package mips_pkg holds:
  - ALU op localparams;
  - opcode/funct localparams;
  - reg_dst, mem2reg and srcA/srcB select encodings.
- One natural sub-module: mips_alu_core (combinational ALU, op + A + B → result, overflow). Decoder and extender stay inline.

Test Plan:
- Reset low mid-run → all outputs 0 immediately, with no clock edge.
- addi $t0, $t1, -1 with rs_data = 5 → next cycle ext_imm = 0xFFFFFFFF, alu_result = 4, reg_dst = 0, reg_wr = 1.
- sll rd, rt, 4 with rt_data = 0x0000000F → alu_result = 0x000000F0. sra by 4 on 0x80000000 → 0xF8000000.
- lui 0x1234 → alu_result = 0x12340000. ori 0x8000 with rs = 0 → 0x00008000 (zero-extended).
- beq with rs = rt = 7 → zero = 1, reg_wr = 0, mem_wr = 0. sw → mem_wr = 1, store_data = rt_data.
- With OVF_TRAP_EN: add 0x7FFFFFFF + 1 → overflow = 1, reg_wr = 0. Same operands with addu → result 0x80000000, overflow = 0, reg_wr = 1.
